ram_scan_reader: RTL and testbench
==================================

RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, as the width of one RAM element.
REQ-002 The block SHALL take parameter ROWS, default 4, as the number of RAM rows scanned.
REQ-003 The block SHALL take parameter COLS, default 32, as the number of RAM columns scanned.
REQ-004 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-006 Port start  input  1  is a one-cycle scan request, honoured only in IDLE.
REQ-007 Port busy  output  1  is high from the cycle after start is accepted until the last element is accepted.
REQ-008 Port done  output  1  is a one-cycle pulse in the cycle after the final element handshake.
REQ-009 Port r_row  output  $clog2(ROWS)  is the RAM read row address.
REQ-010 Port r_col  output  $clog2(COLS)  is the RAM read column address.
REQ-011 Port rd_data  input  DATA_WIDTH  is the registered RAM read data, valid exactly 1 cycle after its address.
REQ-012 Port out_data  output  DATA_WIDTH  is the streamed element.
REQ-013 Port out_valid  output  1  marks out_data as valid.
REQ-014 Port out_ready  input  1  is the consumer's acceptance; a transfer occurs when out_valid and out_ready are both high.
REQ-015 Port out_row_last  output  1  flags the element at column COLS-1 of any row.
REQ-016 Port out_last  output  1  flags the element at row ROWS-1, column COLS-1.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN and DRAIN.
REQ-018 In IDLE, start=1 SHALL load the address to (0,0) and enter SCAN.
REQ-019 In SCAN, a read SHALL be issued when occupancy + inflight - pop < 2.
REQ-020 The terms of REQ-019 are: occupancy is the output buffer count, inflight is 1 if a read was issued last cycle, and pop is the current-cycle handshake.
REQ-021 The address SHALL advance on each issued read in row-major order: col+1, wrapping to 0 with row+1.
REQ-022 After issuing (ROWS-1, COLS-1), the FSM SHALL enter DRAIN.
REQ-023 In DRAIN, the FSM SHALL enter IDLE when the buffer is empty and no read is in flight.
REQ-024 done SHALL be asserted in the cycle after the REQ-023 transition.
REQ-025 Returned rd_data SHALL be written into a 2-entry FIFO together with its row_last and last tags.
REQ-026 The FIFO SHALL never overflow; REQ-019 guarantees this.
REQ-027 out_valid SHALL equal FIFO non-empty, and out_data, out_row_last and out_last SHALL come from the FIFO head.
REQ-028 With out_ready held high, the first element SHALL appear 2 cycles after start.
REQ-029 With out_ready held high, the block SHALL sustain one element per cycle thereafter.
REQ-030 A full scan SHALL deliver exactly ROWS*COLS elements, in order, with no duplicates or drops under any out_ready pattern.
REQ-031 While out_valid=1 and out_ready=0, out_data and its tags SHALL stay stable.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 start arriving in the same cycle as done SHALL be ignored.
REQ-034 When ROWS=1 or COLS=1, wrap logic SHALL stay correct, with row_last on every element when COLS=1.

Reset
REQ-035 rst_n=0 SHALL immediately force: state IDLE, busy 0, done 0, out_valid 0, FIFO empty, inflight 0, r_row 0, r_col 0.
REQ-036 Reset mid-scan SHALL discard all buffered and in-flight data; no element SHALL be emitted after reset release until a new start.

Structure
REQ-037 The FSM state encoding SHALL live in a shared package, since the write-side controller reuses its IDLE/busy/done conventions.
REQ-038 The 2-entry FIFO SHALL be a sub-module named skid_fifo2, parameterised by width (DATA_WIDTH+2).
REQ-039 The block SHALL have no combinational path from rd_data to any output.

Verification
REQ-040 ROWS=4, COLS=32, RAM preloaded with mem[r][c]=r*32+c, out_ready=1, start pulse -> out_data 0..127 on consecutive cycles; first element 2 cycles after start; row_last at 31/63/95/127; last at 127; done one cycle later.
REQ-041 Same preload, out_ready toggling 1,0,0,1 repeating -> identical 0..127 sequence, data stable while stalled, inflight FIFO count never exceeds 2.
REQ-042 start re-pulsed at element 10 and again in the done cycle -> second scan not started; exactly 128 elements.
REQ-043 rst_n low at element 50 with out_ready=0 -> out_valid 0, busy 0 asynchronously; after release and new start, stream restarts at 0.
REQ-044 ROWS=1, COLS=1, mem=0xA5 -> single element 0xA5 with row_last=1 and last=1, then done.

Source files
------------

// File: rtl/ram_scan_reader_pkg.sv
// rtl/ram_scan_reader_pkg.sv - shared scan FSM encoding and address-width helper
package ram_scan_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    localparam int FIFO_DEPTH = 2;

    // A one-entry dimension still needs a 1-bit address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_scan_reader_skid_fifo2.sv
// rtl/ram_scan_reader_skid_fifo2.sv - two-entry registered FIFO for RAM return data
module skid_fifo2 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - row-major RAM scanner streaming elements with backpressure
module ram_scan_reader
    import ram_scan_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [addr_w(ROWS)-1:0]   r_row,
    output logic [addr_w(COLS)-1:0]   r_col,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_row_last,
    output logic                      out_last
);

    localparam int RW = addr_w(ROWS);
    localparam int CW = addr_w(COLS);
    localparam int FW = DATA_WIDTH + 2;

    scan_state_e   state;
    scan_state_e   state_nxt;
    logic          issue;
    logic          accept;
    logic          pop;
    logic          inflight;
    logic          tag_row_last;
    logic          tag_last;
    logic          at_row_end;
    logic          at_end;
    logic [1:0]    occ;
    logic [2:0]    pending;
    logic [FW-1:0] head;

    assign pop        = out_valid && out_ready;
    assign accept     = start && !done;
    assign at_row_end = (r_col == CW'(COLS - 1));
    assign at_end     = at_row_end && (r_row == RW'(ROWS - 1));
    // Elements the FIFO will hold once this cycle's pop and the in-flight read settle.
    assign pending    = 3'(occ) + 3'(inflight) - 3'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (issue && at_end) state_nxt = DRAIN;
            DRAIN:   if (pending == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b1;
        case (state)
            IDLE:    busy  = 1'b0;
            SCAN:    issue = (pending < 3'(FIFO_DEPTH));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            inflight     <= 1'b0;
            tag_row_last <= 1'b0;
            tag_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= (state == DRAIN) && (state_nxt == IDLE);
            if (state == IDLE && accept) begin
                r_row <= '0;
                r_col <= '0;
            end else if (issue) begin
                tag_row_last <= at_row_end;
                tag_last     <= at_end;
                if (at_row_end) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // rd_data is captured only into FIFO registers, so outputs never see it combinationally.
    skid_fifo2 #(
        .WIDTH(FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({tag_last, tag_row_last, rd_data}),
        .pop       (pop),
        .head      (head),
        .count     (occ)
    );

    assign out_valid    = (occ != 2'd0);
    assign out_data     = head[DATA_WIDTH-1:0];
    assign out_row_last = head[DATA_WIDTH];
    assign out_last     = head[DATA_WIDTH+1];

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb/tb_ram_scan_reader.sv - self-checking bench for ram_scan_reader
module tb_ram_scan_reader;

    localparam int ROWS  = 4;
    localparam int COLS  = 32;
    localparam int TOTAL = ROWS * COLS;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] r_row;
    logic [4:0] r_col;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_row_last;
    logic       out_last;

    logic       start1;
    logic       busy1;
    logic       done1;
    logic [0:0] r_row1;
    logic [0:0] r_col1;
    logic [7:0] rd_data1;
    logic [7:0] out_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic       out_row_last1;
    logic       out_last1;

    logic [7:0] mem [ROWS][COLS];
    logic [7:0] mem1;

    int checks   = 0;
    int failures = 0;

    int got_data[$];
    int got_rl[$];
    int got_last[$];
    int got_cyc[$];
    int done_cnt;
    int done_cyc;
    int stab_err;
    int busy_err;

    ram_scan_reader #(.DATA_WIDTH(8), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .r_row(r_row), .r_col(r_col), .rd_data(rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row_last(out_row_last), .out_last(out_last)
    );

    ram_scan_reader #(.DATA_WIDTH(8), .ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .r_row(r_row1), .r_col(r_col1), .rd_data(rd_data1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_row_last(out_row_last1), .out_last(out_last1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rd_data  <= mem[r_row][r_col];
        rd_data1 <= mem1;
    end

    task automatic preload(input bit randomize);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = randomize ? 8'($urandom_range(0, 255)) : 8'(r * COLS + c);
    endtask

    // Drives one scan and records every handshake; mode 0 ready high, 1 pattern 1,0,0,1, 2 random.
    task automatic run_scan(input int mode, input bit repulse);
        int   cyc;
        logic pv;
        logic pr;
        logic [9:0] ph;
        logic exp_busy;
        got_data.delete(); got_rl.delete(); got_last.delete(); got_cyc.delete();
        done_cnt = 0; done_cyc = -1; stab_err = 0; busy_err = 0;
        pv = 1'b0; pr = 1'b0; ph = '0;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (cyc < 4000 && !(done_cnt > 0 && cyc >= done_cyc + 4)) begin
            @(posedge clk);
            cyc++;
            #1;
            start = repulse && (got_data.size() == 10 || done);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            exp_busy = (got_data.size() < TOTAL);
            if (busy !== exp_busy) busy_err++;
            if (pv && !pr && (!out_valid || {out_last, out_row_last, out_data} !== ph)) stab_err++;
            if (out_valid && out_ready) begin
                got_data.push_back(int'(out_data));
                got_rl.push_back(int'(out_row_last));
                got_last.push_back(int'(out_last));
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            pv = out_valid;
            pr = out_ready;
            ph = {out_last, out_row_last, out_data};
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, out_valid, r_row, r_col} !== 10'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b valid=%b row=%0d col=%0d expected all 0",
                     busy, done, out_valid, r_row, r_col);
        end
        checks++;
        if ({busy1, done1, out_valid1} !== 3'd0) begin
            failures++;
            $display("FAIL reset_state_1x1 got busy=%b done=%b valid=%b expected 0", busy1, done1, out_valid1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stream(input string name);
        checks++;
        if (got_data.size() != TOTAL) begin
            failures++;
            $display("FAIL %s_count got %0d expected %0d", name, got_data.size(), TOTAL);
        end
        for (int i = 0; i < got_data.size() && i < TOTAL; i++) begin
            int exp_d;
            exp_d = int'(mem[i / COLS][i % COLS]);
            checks++;
            if (got_data[i] != exp_d || got_rl[i] != int'(i % COLS == COLS - 1) ||
                got_last[i] != int'(i == TOTAL - 1)) begin
                failures++;
                $display("FAIL %s_elem[%0d] got data=%0d rl=%0d last=%0d expected data=%0d rl=%0d last=%0d",
                         name, i, got_data[i], got_rl[i], got_last[i],
                         exp_d, int'(i % COLS == COLS - 1), int'(i == TOTAL - 1));
            end
        end
        checks++;
        if (done_cnt != 1 || got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size() - 1] + 1) begin
            failures++;
            $display("FAIL %s_done got pulses=%0d at cycle %0d expected 1 pulse one cycle after last element",
                     name, done_cnt, done_cyc);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s_busy got %0d bad cycles expected 0", name, busy_err);
        end
    endtask

    task automatic test_full_stream();
        preload(1'b0);
        run_scan(0, 1'b0);
        check_stream("full");
        for (int i = 0; i < got_cyc.size() && i < TOTAL; i++) begin
            checks++;
            if (got_cyc[i] != 3 + i) begin
                failures++;
                $display("FAIL full_timing[%0d] got cycle %0d expected %0d", i, got_cyc[i], 3 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        preload(1'b0);
        run_scan(1, 1'b0);
        check_stream("bp");
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL bp_stable got %0d unstable stall cycles expected 0", stab_err);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            preload(1'b1);
            run_scan(2, 1'b0);
            check_stream("rand");
            checks++;
            if (stab_err != 0) begin
                failures++;
                $display("FAIL rand_stable got %0d unstable stall cycles expected 0", stab_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        preload(1'b0);
        run_scan(0, 1'b1);
        check_stream("restart");
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        int leak;
        preload(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 50 && cyc < 500) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd50) begin
            failures++;
            $display("FAIL rst_mid_stall got valid=%b data=%0d expected valid=1 data=50", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || r_row !== 2'd0 || r_col !== 5'd0) begin
            failures++;
            $display("FAIL rst_mid_async got valid=%b busy=%b row=%0d col=%0d expected 0", out_valid, busy, r_row, r_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        leak = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || busy) leak++;
        end
        checks++;
        if (leak != 0) begin
            failures++;
            $display("FAIL rst_mid_leak got %0d active cycles after release expected 0", leak);
        end
        run_scan(0, 1'b0);
        check_stream("rst_restart");
    endtask

    task automatic test_single();
        int cyc;
        int n;
        int first;
        int dcyc;
        int dcnt;
        logic [9:0] seen;
        mem1 = 8'hA5;
        n = 0; first = -1; dcyc = -1; dcnt = 0; seen = '0;
        @(posedge clk); #1;
        start1 = 1'b1;
        out_ready1 = 1'b1;
        for (cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            @(negedge clk);
            if (out_valid1 && out_ready1) begin
                n++;
                first = cyc;
                seen = {out_last1, out_row_last1, out_data1};
            end
            if (done1) begin
                dcnt++;
                dcyc = cyc;
            end
        end
        checks++;
        if (n != 1 || seen !== {1'b1, 1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL single_elem got count=%0d last/rl/data=%h expected 1 elem 3a5", n, seen);
        end
        checks++;
        if (first != 3 || dcnt != 1 || dcyc != 4) begin
            failures++;
            $display("FAIL single_timing got elem@%0d done@%0d pulses=%0d expected 3 4 1", first, dcyc, dcnt);
        end
        checks++;
        if (r_row1 !== 1'b0 || r_col1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got row=%b col=%b busy=%b expected 0", r_row1, r_col1, busy1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        start1 = 1'b0;
        out_ready1 = 1'b0;
        mem1 = 8'h00;
        preload(1'b0);
        test_reset();
        test_full_stream();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
